// File: rtl/isqrt_pkg.sv
// isqrt_pkg: width constants and a reference integer square root
//   ISQRT_X_W  radicand width
//   ISQRT_Y_W  root width
//   isqrt_ref  floor(sqrt(x)) by binary search over the root range
package isqrt_pkg;
   localparam int ISQRT_X_W = 32;
   localparam int ISQRT_Y_W = 16;
   function automatic logic [ISQRT_Y_W-1:0] isqrt_ref(input logic [ISQRT_X_W-1:0] x);
      longint lo, hi, mid;
      lo = 0;
      hi = (longint'(1) << ISQRT_Y_W) - 1;
      for (int i = 0; i <= ISQRT_Y_W; i++) begin
         mid = (lo + hi + 1) / 2;
         if (lo < hi) begin
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid - 1;
         end
      end
      return ISQRT_Y_W'(lo);
   endfunction
endpackage

// File: rtl/isqrt_stage.sv
// isqrt_stage: resolves ITER_PER_STAGE root bits starting at FIRST_BIT, then registers them
//   clk, rst       clock, synchronous active-high reset (valid only)
//   vld_i, vld_o   request valid in / registered out
//   x_i, x_o       radicand in / registered out
//   q_i, q_o       partial root in / registered out with this stage's bits resolved
module isqrt_stage import isqrt_pkg::*; #(
   parameter int ITER_PER_STAGE = 1,
   parameter int FIRST_BIT      = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 vld_i,
   input  logic [ISQRT_X_W-1:0] x_i,
   input  logic [ISQRT_Y_W-1:0] q_i,
   output logic                 vld_o,
   output logic [ISQRT_X_W-1:0] x_o,
   output logic [ISQRT_Y_W-1:0] q_o
);
   logic                 vld_q;
   logic [ISQRT_X_W-1:0] x_q;
   logic [ISQRT_Y_W-1:0] q_q, q_d, cand;
   // cand fits 16 bits, so its 32-bit square never exceeds 0xFFFE_0001
   always_comb begin
      q_d  = q_i;
      cand = '0;
      for (int k = 0; k < ITER_PER_STAGE; k++) begin
         cand = q_d | (ISQRT_Y_W'(1) << (FIRST_BIT - k));
         q_d  = (ISQRT_X_W'(cand) * ISQRT_X_W'(cand) <= x_i) ? cand : q_d;
      end
   end
   always_ff @(posedge clk) begin
      vld_q <= rst ? 1'b0 : vld_i;
      x_q   <= x_i;
      q_q   <= q_d;
   end
   assign vld_o = vld_q;
   assign x_o   = x_q;
   assign q_o   = q_q;
endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: pipelined floor(sqrt(x)), one request per clock, fixed latency 16/ITER_PER_STAGE
//   clk, rst  clock, synchronous active-high reset
//   x_vld, x  request valid and 32-bit radicand
//   y_vld, y  registered one-cycle result valid and 16-bit root
module isqrt_pipe import isqrt_pkg::*; #(
   parameter int ITER_PER_STAGE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 x_vld,
   input  logic [ISQRT_X_W-1:0] x,
   output logic                 y_vld,
   output logic [ISQRT_Y_W-1:0] y
);
   localparam int LATENCY = ISQRT_Y_W / ITER_PER_STAGE;
   logic                 vld_w [0:LATENCY];
   logic [ISQRT_X_W-1:0] x_w   [0:LATENCY];
   logic [ISQRT_Y_W-1:0] q_w   [0:LATENCY];
   logic                 unused_x;
   assign vld_w[0] = x_vld;
   assign x_w[0]   = x;
   assign q_w[0]   = '0;
   for (genvar s = 0; s < LATENCY; s++) begin : g_stage
      isqrt_stage #(
         .ITER_PER_STAGE(ITER_PER_STAGE),
         .FIRST_BIT     (ISQRT_Y_W - 1 - s * ITER_PER_STAGE)
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .vld_i(vld_w[s]),
         .x_i  (x_w[s]),
         .q_i  (q_w[s]),
         .vld_o(vld_w[s+1]),
         .x_o  (x_w[s+1]),
         .q_o  (q_w[s+1])
      );
   end
   // the last stage's radicand copy has no consumer
   assign unused_x = ^x_w[LATENCY];
   assign y_vld    = vld_w[LATENCY];
   assign y        = q_w[LATENCY];
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: scoreboard bench sweeping ITER_PER_STAGE over 1, 2, 4, 8, 16 on shared stimulus
module tb_isqrt_pipe;
   import isqrt_pkg::*;
   typedef struct {
      logic [15:0] e;
      int          due;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;
   logic [15:0] x_exp;
   bit          use_tab;
   bit          done;
   int          n = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   always #5 clk = ~clk;
   always @(negedge clk) n++;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, n);
      end
   endtask
   for (genvar g = 0; g < 5; g++) begin : g_sw
      localparam int IPS = 1 << g;
      localparam int LAT = 16 / IPS;
      logic        y_vld;
      logic [15:0] y;
      exp_t        exp_q[$];
      bit          fin;
      isqrt_pipe #(.ITER_PER_STAGE(IPS)) dut (
         .clk  (clk),
         .rst  (rst),
         .x_vld(x_vld),
         .x    (x),
         .y_vld(y_vld),
         .y    (y)
      );
      always @(posedge clk) begin
         if (rst) exp_q.delete();
         else if (x_vld) exp_q.push_back(exp_t'{use_tab ? x_exp : isqrt_ref(x), n + LAT - 1});
         #1;
         if (exp_q.size() != 0 && exp_q[0].due == n) begin
            check($sformatf("ips%0d_vld", IPS), 32'(y_vld), 32'd1);
            check($sformatf("ips%0d_y", IPS), 32'(y), 32'(exp_q[0].e));
            void'(exp_q.pop_front());
         end else begin
            check($sformatf("ips%0d_idle", IPS), 32'(y_vld), 32'd0);
         end
         if (done && !fin) begin
            check($sformatf("ips%0d_drain", IPS), 32'(exp_q.size()), 32'd0);
            fin = 1'b1;
         end
      end
   end
   task automatic drive(input logic v, input logic [31:0] xv, input logic [15:0] e);
      @(negedge clk);
      x_vld = v;
      x     = xv;
      x_exp = e;
   endtask
   task automatic idle(input int c);
      repeat (c) drive(1'b0, 32'd0, 16'd0);
   endtask
   logic [31:0] sx [7] = '{0, 1, 2, 3, 4, 15, 16};
   logic [15:0] sy [7] = '{0, 1, 1, 1, 2, 3, 4};
   logic [31:0] bx [4] = '{32'hFFFF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000, 32'h4000_0000};
   logic [15:0] by [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h8000};
   logic        mv [5] = '{1, 1, 0, 1, 1};
   logic [31:0] mx [5] = '{100, 101, 0, 99, 10000};
   logic [15:0] my [5] = '{10, 10, 0, 9, 100};
   initial begin
      rst     = 1'b1;
      x_vld   = 1'b0;
      x       = '0;
      x_exp   = '0;
      use_tab = 1'b1;
      done    = 1'b0;
      idle(3);
      rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, sx[i], sy[i]);
         idle(17);
      end
      for (int i = 0; i < 4; i++) drive(1'b1, bx[i], by[i]);
      idle(17);
      for (int i = 0; i < 5; i++) drive(mv[i], mx[i], my[i]);
      idle(17);
      use_tab = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 16'd0);
      idle(2);
      drive(1'b1, 32'd1234, 16'd0);
      rst = 1'b1;
      drive(1'b1, 32'd144, 16'd0);
      rst = 1'b0;
      idle(17);
      for (int i = 0; i < 10000; i++) drive(1'b1, $urandom, 16'd0);
      for (int i = 0; i < 500; i++) drive(1'($urandom_range(0, 1)), $urandom, 16'd0);
      idle(20);
      done = 1'b1;
      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
